score_display_ctrl: RTL and testbench

- Game-side controller that owns the score and high-score registers and sequences what the two-digit seven-segment decoder shows.
- Counts food events during play, with saturation.
- Latches a new high score at game over.
- Blinks the final score for a fixed time, then returns to showing the high score.
- Drives the 7-bit score input of the existing decoder and a blank control that gates HEX1/HEX0 at top level.

---
 rtl/score_display_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_score_display_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/score_display_ctrl.sv
// Score / high-score keeper and display sequencer for the two-digit 7-seg decoder.
// Optional macro SCORE_ALT_EN: IDLE alternates between the high score and the last game's score.
module score_display_ctrl #(
    parameter int TICK_DIV    = 5_000_000,
    parameter int BLINK_TICKS = 3,
    parameter int OVER_TICKS  = 30,
    parameter int ALT_TICKS   = 20,
    parameter int MAX_SCORE   = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_start,
    input  logic       food_eaten,
    input  logic       game_over,
    output logic [6:0] disp_score,
    output logic       disp_blank,
    output logic [6:0] hi_score,
    output logic       new_record,
    output logic       disp_is_hi
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BLINK_TICKS + 1);
    localparam int OW = $clog2(OVER_TICKS + 1);

    if (TICK_DIV < 2 || MAX_SCORE > 99 || MAX_SCORE < 1 || ALT_TICKS < 1 ||
        BLINK_TICKS < 1 || OVER_TICKS < 1) begin : g_bad_params
        $error("score_display_ctrl: illegal parameter value");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    function automatic logic [6:0] sat_inc(input logic [6:0] v);
        if (v >= 7'(MAX_SCORE)) return 7'(MAX_SCORE);
        return v + 7'd1;
    endfunction

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic [OW-1:0] over_cnt_q, over_cnt_d;
    logic [6:0]    score_q, score_d;
    logic [6:0]    hi_q, hi_d;
    logic [6:0]    disp_score_q, disp_score_d;
    logic          disp_blank_q, disp_blank_d;
    logic          new_record_q, new_record_d;
    logic          disp_is_hi_q, disp_is_hi_d;
    logic          tick;
`ifdef SCORE_ALT_EN
    localparam int AW = $clog2(ALT_TICKS + 1);
    logic [AW-1:0] alt_cnt_q, alt_cnt_d;
    logic          alt_phase_q, alt_phase_d;
`endif

    always_comb begin
        tick         = (pre_q == PW'(TICK_DIV - 1));
        pre_d        = tick ? '0 : pre_q + PW'(1);
        state_d      = state_q;
        score_d      = score_q;
        hi_d         = hi_q;
        new_record_d = new_record_q;
        disp_blank_d = disp_blank_q;
        blink_cnt_d  = blink_cnt_q;
        over_cnt_d   = over_cnt_q;

        case (state_q)
            IDLE: begin
                if (game_start) begin
                    state_d      = PLAY;
                    score_d      = '0;
                    new_record_d = 1'b0;
                    disp_blank_d = 1'b0;
                end
            end
            PLAY: begin
                // Increment first so a simultaneous game_over judges the final score.
                if (food_eaten) score_d = sat_inc(score_q);
                if (game_over) begin
                    state_d      = OVER;
                    blink_cnt_d  = '0;
                    over_cnt_d   = '0;
                    disp_blank_d = 1'b0;
                    if (score_d > hi_q) begin
                        hi_d         = score_d;
                        new_record_d = 1'b1;
                    end
                end
            end
            OVER: begin
                if (game_start) begin
                    state_d      = PLAY;
                    score_d      = '0;
                    new_record_d = 1'b0;
                    disp_blank_d = 1'b0;
                end else if (tick) begin
                    if (over_cnt_q + OW'(1) == OW'(OVER_TICKS)) begin
                        state_d      = IDLE;
                        over_cnt_d   = '0;
                        blink_cnt_d  = '0;
                        disp_blank_d = 1'b0;
                    end else begin
                        over_cnt_d = over_cnt_q + OW'(1);
                        if (blink_cnt_q + BW'(1) == BW'(BLINK_TICKS)) begin
                            blink_cnt_d  = '0;
                            disp_blank_d = ~disp_blank_q;
                        end else begin
                            blink_cnt_d = blink_cnt_q + BW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef SCORE_ALT_EN
        alt_cnt_d   = alt_cnt_q;
        alt_phase_d = alt_phase_q;
        if (state_q != IDLE) begin
            alt_cnt_d   = '0;
            alt_phase_d = 1'b0;
        end else if (tick) begin
            if (alt_cnt_q + AW'(1) == AW'(ALT_TICKS)) begin
                alt_cnt_d   = '0;
                alt_phase_d = ~alt_phase_q;
            end else begin
                alt_cnt_d = alt_cnt_q + AW'(1);
            end
        end
`endif

        // Display is derived from next-state values so it tracks events with one cycle latency.
        if (state_d == IDLE) begin
`ifdef SCORE_ALT_EN
            disp_score_d = alt_phase_d ? score_d : hi_d;
            disp_is_hi_d = ~alt_phase_d;
`else
            disp_score_d = hi_d;
            disp_is_hi_d = 1'b1;
`endif
        end else begin
            disp_score_d = score_d;
            disp_is_hi_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pre_q        <= '0;
            blink_cnt_q  <= '0;
            over_cnt_q   <= '0;
            score_q      <= '0;
            hi_q         <= '0;
            disp_score_q <= '0;
            disp_blank_q <= 1'b0;
            new_record_q <= 1'b0;
            disp_is_hi_q <= 1'b1;
`ifdef SCORE_ALT_EN
            alt_cnt_q    <= '0;
            alt_phase_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            blink_cnt_q  <= blink_cnt_d;
            over_cnt_q   <= over_cnt_d;
            score_q      <= score_d;
            hi_q         <= hi_d;
            disp_score_q <= disp_score_d;
            disp_blank_q <= disp_blank_d;
            new_record_q <= new_record_d;
            disp_is_hi_q <= disp_is_hi_d;
`ifdef SCORE_ALT_EN
            alt_cnt_q    <= alt_cnt_d;
            alt_phase_q  <= alt_phase_d;
`endif
        end
    end

    assign disp_score = disp_score_q;
    assign disp_blank = disp_blank_q;
    assign hi_score   = hi_q;
    assign new_record = new_record_q;
    assign disp_is_hi = disp_is_hi_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Scoreboard bench for score_display_ctrl: stimulus queues expected outputs keyed by cycle,
// a negedge monitor pops and compares them.
module tb_score_display_ctrl;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       game_start = 1'b0;
    logic       food_eaten = 1'b0;
    logic       game_over = 1'b0;
    logic [6:0] disp_score;
    logic       disp_blank;
    logic [6:0] hi_score;
    logic       new_record;
    logic       disp_is_hi;

    score_display_ctrl #(
        .TICK_DIV   (TD),
        .BLINK_TICKS(2),
        .OVER_TICKS (8),
        .ALT_TICKS  (20),
        .MAX_SCORE  (99)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .game_start(game_start),
        .food_eaten(food_eaten),
        .game_over (game_over),
        .disp_score(disp_score),
        .disp_blank(disp_blank),
        .hi_score  (hi_score),
        .new_record(new_record),
        .disp_is_hi(disp_is_hi)
    );

    always #5 clk = ~clk;

    int unsigned cyc  = 0;
    int unsigned ecnt = 0;

    // ecnt counts edges since reset release; the prescaler ticks on edges where ecnt % TD == 0.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    typedef struct packed {
        logic [31:0] k;
        logic [6:0]  ds;
        logic        bl;
        logic [6:0]  hi;
        logic        nr;
        logic        ih;
    } exp_t;

    exp_t  q[$];
    string qn[$];
    int    nvec  = 0;
    int    nfail = 0;

    task automatic exp_at(input int unsigned k, input int ds, input int bl, input int hi,
                          input int nr, input int ih, input string nm);
        exp_t e;
        e.k  = k;
        e.ds = 7'(ds);
        e.bl = 1'(bl);
        e.hi = 7'(hi);
        e.nr = 1'(nr);
        e.ih = 1'(ih);
        q.push_back(e);
        qn.push_back(nm);
    endtask

    task automatic exp1(input int ds, input int bl, input int hi, input int nr, input int ih,
                        input string nm);
        exp_at(cyc + 1, ds, bl, hi, nr, ih, nm);
    endtask

    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].k <= cyc) begin
                nvec++;
                if (q[i].k < cyc ||
                    {disp_score, disp_blank, hi_score, new_record, disp_is_hi} !=
                    {q[i].ds, q[i].bl, q[i].hi, q[i].nr, q[i].ih}) begin
                    nfail++;
                    $display("FAIL %s @cyc %0d: got ds=%0d blank=%0d hi=%0d rec=%0d is_hi=%0d, expected ds=%0d blank=%0d hi=%0d rec=%0d is_hi=%0d (due cyc %0d)",
                             qn[i], cyc, disp_score, disp_blank, hi_score, new_record, disp_is_hi,
                             q[i].ds, q[i].bl, q[i].hi, q[i].nr, q[i].ih, q[i].k);
                end
                q.delete(i);
                qn.delete(i);
            end
        end
    end

    task automatic pulse(input logic s, input logic f, input logic o);
        game_start = s;
        food_eaten = f;
        game_over  = o;
        @(negedge clk);
        game_start = 1'b0;
        food_eaten = 1'b0;
        game_over  = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at a negedge whose following edge is a prescaler tick.
    task automatic align();
        while (ecnt % TD != TD - 1) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, cycle %0d, required under %0d", cyc, 20000);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned b;

        // Reset held for two edges, then released
        exp_at(1, 0, 0, 0, 0, 1, "reset edge1");
        exp_at(2, 0, 0, 0, 0, 1, "reset edge2");
        step(2);
        rst_n = 1'b1;
        exp1(0, 0, 0, 0, 1, "after release");
        step(1);

        // First game: 5 food, game_over on a tick edge, full blink / timeout sequence
        align();
        exp1(0, 0, 0, 0, 0, "g1 start");
        pulse(1, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            exp1(i, 0, 0, 0, 0, "g1 food");
            pulse(0, 1, 0);
        end
        align();
        b = cyc;
        exp_at(b + 1,  5, 0, 5, 1, 0, "g1 over record");
        exp_at(b + 8,  5, 0, 5, 1, 0, "g1 blank before 2 ticks");
        exp_at(b + 9,  5, 1, 5, 1, 0, "g1 blank on");
        exp_at(b + 16, 5, 1, 5, 1, 0, "g1 blank held");
        exp_at(b + 17, 5, 0, 5, 1, 0, "g1 blank off");
        exp_at(b + 25, 5, 1, 5, 1, 0, "g1 blank on again");
        exp_at(b + 32, 5, 1, 5, 1, 0, "g1 still OVER");
        exp_at(b + 33, 5, 0, 5, 1, 1, "g1 back to IDLE");
        pulse(0, 0, 1);
        step(32);

        // Second game: 3 food, lower score, blinks 3
        exp1(0, 0, 5, 0, 0, "g2 start");
        pulse(1, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            exp1(i, 0, 5, 0, 0, "g2 food");
            pulse(0, 1, 0);
        end
        align();
        b = cyc;
        exp_at(b + 1, 3, 0, 5, 0, 0, "g2 over no record");
        exp_at(b + 9, 3, 1, 5, 0, 0, "g2 blinks 3");
        pulse(0, 0, 1);
        step(8);

        // Third game: equal score is not a record
        exp1(0, 0, 5, 0, 0, "g3 start from OVER");
        pulse(1, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            exp1(i, 0, 5, 0, 0, "g3 food");
            pulse(0, 1, 0);
        end
        exp1(5, 0, 5, 0, 0, "g3 equal not record");
        pulse(0, 0, 1);

        // Saturation at 99
        exp1(0, 0, 5, 0, 0, "g4 start");
        pulse(1, 0, 0);
        for (int i = 1; i <= 120; i++) begin
            exp1((i > 99) ? 99 : i, 0, 5, 0, 0, "g4 food sat");
            pulse(0, 1, 0);
        end
        exp1(99, 0, 99, 1, 0, "g4 over 99");
        pulse(0, 0, 1);

        // Reset clears hi_score, then IDLE ignore rules
        rst_n = 1'b0;
        exp1(0, 0, 0, 0, 1, "reset2 edge1");
        step(1);
        exp1(0, 0, 0, 0, 1, "reset2 edge2");
        step(1);
        rst_n = 1'b1;
        exp1(0, 0, 0, 0, 1, "idle food ignored");
        pulse(0, 1, 0);
        exp1(0, 0, 0, 0, 1, "idle over ignored");
        pulse(0, 0, 1);
        exp1(0, 0, 0, 0, 0, "idle start beats over");
        pulse(1, 0, 1);
        for (int i = 1; i <= 7; i++) begin
            exp1(i, 0, 0, 0, 0, "g5 food");
            pulse(0, 1, 0);
        end
        exp1(7, 0, 0, 0, 0, "play start ignored");
        pulse(1, 0, 0);
        exp1(7, 0, 7, 1, 0, "g5 over hi 7");
        pulse(0, 0, 1);

        // Score 7 vs hi 7: food and game_over together
        exp1(0, 0, 7, 0, 0, "g6 start");
        pulse(1, 0, 0);
        for (int i = 1; i <= 7; i++) begin
            exp1(i, 0, 7, 0, 0, "g6 food");
            pulse(0, 1, 0);
        end
        align();
        b = cyc;
        exp_at(b + 1, 8, 0, 8, 1, 0, "food+over record");
        exp_at(b + 9, 8, 1, 8, 1, 0, "g6 blank on");
        pulse(0, 1, 1);
        step(8);

        // game_start while blanked, then reset mid-PLAY
        exp1(0, 0, 8, 0, 0, "start while blanked");
        pulse(1, 0, 0);
        for (int i = 1; i <= 2; i++) begin
            exp1(i, 0, 8, 0, 0, "g7 food");
            pulse(0, 1, 0);
        end
        rst_n = 1'b0;
        exp1(0, 0, 0, 0, 1, "mid-play reset edge1");
        step(1);
        exp1(0, 0, 0, 0, 1, "mid-play reset edge2");
        step(1);
        rst_n = 1'b1;
        exp1(0, 0, 0, 0, 1, "after mid-play reset");
        step(3);

        if (q.size() != 0) begin
            $display("FAIL scoreboard drain: %0d entries left, required 0", q.size());
            nfail += q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
